// File: rtl/updown_counter_pkg.sv
// Shared definitions for the parametrised up/down counter: mode encodings and
// the load-path clamp helper.
package updown_counter_pkg;

    localparam int CNT_MODE_WRAP = 0;
    localparam int CNT_MODE_SAT  = 1;

    // Operands are carried at 64 bits so one helper serves every counter width.
    function automatic logic [63:0] clamp_to_max(input logic [63:0] value,
                                                 input logic [63:0] max_value);
        return (value > max_value) ? max_value : value;
    endfunction

endpackage

// File: rtl/updown_counter_param_addsub.sv
// Ripple-carry incrementer/decrementer: adds +1 or all-ones (-1) to a using a
// chain of per-bit full-adder cells.
module addsub_ripple #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic             up,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   carry;

    assign b        = up ? WIDTH'(1) : '1;
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with programmable modulus, wrap/saturate mode,
// synchronous clear and load, registered boundary flags and ovf/unf pulses.
module updown_counter_param
    import updown_counter_pkg::*;
#(
    parameter int              WIDTH     = 4,
    parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
    parameter int              SATURATE  = CNT_MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             at_zero,
    output logic             at_max,
    output logic             ovf,
    output logic             unf
);

    if (WIDTH < 1 || WIDTH > 63) begin : g_bad_width
        $error("updown_counter_param: WIDTH must be in 1..63");
    end
    if (MAX_COUNT < 64'd1 || MAX_COUNT > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $error("updown_counter_param: MAX_COUNT must be in 1..2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MAX_VAL  = MAX_COUNT[WIDTH-1:0];
    localparam bit               SAT_MODE = (SATURATE == CNT_MODE_SAT);

    logic [WIDTH-1:0] step_sum;
    logic             unused_cout;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] next_count;
    logic             next_ovf;
    logic             next_unf;
    logic             is_zero;
    logic             is_max;

    addsub_ripple #(.WIDTH(WIDTH)) u_addsub (
        .a    (count),
        .up   (up),
        .sum  (step_sum),
        .cout (unused_cout)
    );

    // Boundaries come from explicit compares since MAX_COUNT may sit below the adder's natural wrap.
    assign is_zero  = (count == '0);
    assign is_max   = (count == MAX_VAL);
    assign load_val = WIDTH'(clamp_to_max(64'(din), MAX_COUNT));

    always_comb begin
        next_count = count;
        next_ovf   = 1'b0;
        next_unf   = 1'b0;
        if (clr) begin
            next_count = '0;
        end else if (load) begin
            next_count = load_val;
        end else if (en) begin
            if (up) begin
                if (is_max) begin
                    next_ovf   = 1'b1;
                    next_count = SAT_MODE ? MAX_VAL : '0;
                end else begin
                    next_count = step_sum;
                end
            end else begin
                if (is_zero) begin
                    next_unf   = 1'b1;
                    next_count = SAT_MODE ? '0 : MAX_VAL;
                end else begin
                    next_count = step_sum;
                end
            end
        end
    end

    // Flags are derived from next_count so they line up with count in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            at_zero <= 1'b1;
            at_max  <= 1'b0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
        end else begin
            count   <= next_count;
            at_zero <= (next_count == '0);
            at_max  <= (next_count == MAX_VAL);
            ovf     <= next_ovf;
            unf     <= next_unf;
        end
    end

endmodule
